// File: rtl/rv_plic_core.sv
// rv_plic_core: parametrised PLIC core with per-source gateways, per-target
// arbitration, claim-race resolution and complete handling; no register file.
`default_nettype none

module rv_plic_core #(
    parameter int NumSrc    = 64,
    parameter int NumTarget = 2,
    parameter int MaxPrio   = 7,
    parameter int EdgeCntW  = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumSrc-1:0]               intr_src_i,
    input  logic [NumSrc-1:0]               le_i,
    input  logic [NumSrc*$clog2(MaxPrio+1)-1:0]    prio_i,
    input  logic [NumTarget*NumSrc-1:0]     ie_i,
    input  logic [NumTarget*$clog2(MaxPrio+1)-1:0] threshold_i,
    input  logic [NumTarget-1:0]            claim_i,
    output logic [NumTarget*$clog2(NumSrc)-1:0]    claim_id_o,
    input  logic [NumTarget-1:0]            complete_i,
    input  logic [NumTarget*$clog2(NumSrc)-1:0]    complete_id_i,
    output logic [NumSrc-1:0]               ip_o,
    output logic [NumTarget-1:0]            irq_o,
    output logic [NumTarget*$clog2(NumSrc)-1:0]    irq_id_o
);

    localparam int PrioW = $clog2(MaxPrio + 1);
    localparam int SrcW  = $clog2(NumSrc);
    localparam logic [EdgeCntW-1:0] CntMax = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CLAIMED = 2'd2
    } gw_state_e;

    gw_state_e           state_q [NumSrc];
    gw_state_e           state_d [NumSrc];
    gw_state_e           eff     [NumSrc];
    logic [EdgeCntW-1:0] cnt_q   [NumSrc];
    logic [EdgeCntW-1:0] cnt_d   [NumSrc];

    logic [NumSrc-1:0]    src_q;
    logic [NumSrc-1:0]    trig;
    logic [NumSrc-1:0]    edge_trig;
    logic [NumSrc-1:0]    ip;
    logic [NumSrc-1:0]    claimed;
    logic [NumSrc-1:0]    completed;

    logic [NumTarget-1:0] grant;
    logic [NumTarget-1:0] lost;
    logic [NumTarget-1:0] irq_q;
    logic [NumTarget-1:0] irq_d;
    logic [SrcW-1:0]      irq_id_q  [NumTarget];
    logic [SrcW-1:0]      irq_id_d  [NumTarget];
    logic [SrcW-1:0]      best_id   [NumTarget];
    logic [PrioW-1:0]     best_prio [NumTarget];
    logic [SrcW-1:0]      cid       [NumTarget];

    assign edge_trig = le_i & intr_src_i & ~src_q;
    assign trig      = edge_trig | (~le_i & intr_src_i);

    always_comb begin
        ip = '0;
        for (int s = 1; s < NumSrc; s++) begin
            ip[s] = (state_q[s] == PENDING);
        end
    end

    assign ip_o  = ip;
    assign irq_o = irq_q;

    always_comb begin
        irq_id_o = '0;
        for (int t = 0; t < NumTarget; t++) begin
            irq_id_o[t*SrcW +: SrcW] = irq_id_q[t];
        end
    end

    // A lower-index target claiming the same ID in the same cycle wins the race.
    always_comb begin
        grant      = '0;
        lost       = '0;
        claim_id_o = '0;
        for (int t = 0; t < NumTarget; t++) begin
            for (int u = 0; u < t; u++) begin
                if (claim_i[u] && (irq_id_q[u] == irq_id_q[t])) begin
                    lost[t] = 1'b1;
                end
            end
            if (claim_i[t] && (irq_id_q[t] != '0) && ip[irq_id_q[t]] && !lost[t]) begin
                grant[t]                   = 1'b1;
                claim_id_o[t*SrcW +: SrcW] = irq_id_q[t];
            end
        end
    end

    always_comb begin
        claimed   = '0;
        completed = '0;
        for (int t = 0; t < NumTarget; t++) begin
            cid[t] = complete_id_i[t*SrcW +: SrcW];
            if (grant[t]) begin
                claimed[irq_id_q[t]] = 1'b1;
            end
            if (complete_i[t] && (cid[t] != '0) && (int'(cid[t]) < NumSrc)) begin
                completed[cid[t]] = 1'b1;
            end
        end
    end

    // A same-cycle claim is applied first, so a simultaneous complete sees CLAIMED.
    always_comb begin
        for (int s = 0; s < NumSrc; s++) begin
            state_d[s] = state_q[s];
            cnt_d[s]   = cnt_q[s];
            eff[s]     = claimed[s] ? CLAIMED : state_q[s];
            case (eff[s])
                IDLE: begin
                    if (trig[s]) state_d[s] = PENDING;
                end
                PENDING: begin
                    if (edge_trig[s] && (cnt_q[s] != CntMax)) cnt_d[s] = cnt_q[s] + EdgeCntW'(1);
                end
                CLAIMED: begin
                    state_d[s] = CLAIMED;
                    if (completed[s]) begin
                        if (cnt_q[s] != '0) begin
                            state_d[s] = PENDING;
                            if (!edge_trig[s]) cnt_d[s] = cnt_q[s] - EdgeCntW'(1);
                        end else if (trig[s]) begin
                            state_d[s] = PENDING;
                        end else begin
                            state_d[s] = IDLE;
                        end
                    end else if (edge_trig[s] && (cnt_q[s] != CntMax)) begin
                        cnt_d[s] = cnt_q[s] + EdgeCntW'(1);
                    end
                end
                default: state_d[s] = IDLE;
            endcase
            if (s == 0) begin
                state_d[s] = IDLE;
                cnt_d[s]   = '0;
            end
        end
    end

    // Strict greater-than while scanning upwards keeps the lowest ID on ties.
    always_comb begin
        for (int t = 0; t < NumTarget; t++) begin
            best_id[t]   = '0;
            best_prio[t] = '0;
            for (int s = 1; s < NumSrc; s++) begin
                if (ip[s] && ie_i[t*NumSrc + s] && (prio_i[s*PrioW +: PrioW] > best_prio[t])) begin
                    best_prio[t] = prio_i[s*PrioW +: PrioW];
                    best_id[t]   = SrcW'(s);
                end
            end
            irq_d[t]    = (best_prio[t] > threshold_i[t*PrioW +: PrioW]);
            irq_id_d[t] = irq_d[t] ? best_id[t] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q <= '0;
            irq_q <= '0;
            for (int s = 0; s < NumSrc; s++) begin
                state_q[s] <= IDLE;
                cnt_q[s]   <= '0;
            end
            for (int t = 0; t < NumTarget; t++) begin
                irq_id_q[t] <= '0;
            end
        end else begin
            src_q <= intr_src_i;
            irq_q <= irq_d;
            for (int s = 0; s < NumSrc; s++) begin
                state_q[s] <= state_d[s];
                cnt_q[s]   <= cnt_d[s];
            end
            for (int t = 0; t < NumTarget; t++) begin
                irq_id_q[t] <= irq_id_d[t];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rv_plic_core.sv
// Bench for rv_plic_core: directed vectors, a spec-level model checked every
// negedge, plus hand-computed literal expectations.
`default_nettype none

module tb_rv_plic_core;

    localparam int NS = 64;
    localparam int NT = 2;
    localparam int PW = 3;
    localparam int SW = 6;
    localparam int CMAX = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NS-1:0]   src, le;
    logic [NS*PW-1:0] prio;
    logic [NT*NS-1:0] ie;
    logic [NT*PW-1:0] thr;
    logic [NT-1:0]   claim, complete;
    logic [NT*SW-1:0] cid;
    logic [NT*SW-1:0] claim_id;
    logic [NS-1:0]   ip;
    logic [NT-1:0]   irq;
    logic [NT*SW-1:0] irq_id;

    int n_cmp = 0;
    int n_err = 0;

    rv_plic_core #(.NumSrc(NS), .NumTarget(NT), .MaxPrio(7), .EdgeCntW(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .intr_src_i(src), .le_i(le), .prio_i(prio),
        .ie_i(ie), .threshold_i(thr), .claim_i(claim), .claim_id_o(claim_id),
        .complete_i(complete), .complete_id_i(cid), .ip_o(ip), .irq_o(irq),
        .irq_id_o(irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: pending/claimed flags and a queued-edge count per source.
    bit m_pend [NS];
    bit m_clm  [NS];
    int m_cnt  [NS];
    bit m_prev [NS];
    int m_id   [NT];
    bit m_irq  [NT];
    bit m_grant[NT];
    int m_cl   [NT];

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_pend[s] = 0; m_clm[s] = 0; m_cnt[s] = 0; m_prev[s] = 0;
        end
        for (int t = 0; t < NT; t++) begin
            m_id[t] = 0; m_irq[t] = 0;
        end
    endtask

    task automatic model_claims();
        for (int t = 0; t < NT; t++) begin
            bit taken;
            taken = 0;
            for (int u = 0; u < t; u++)
                if (claim[u] && m_id[u] == m_id[t]) taken = 1;
            m_grant[t] = claim[t] && m_id[t] != 0 && m_pend[m_id[t]] && !taken;
            m_cl[t]    = m_grant[t] ? m_id[t] : 0;
        end
    endtask

    task automatic model_step();
        int  nid [NT];
        bit  nirq[NT];
        bit  got [NS];
        bit  done[NS];
        for (int t = 0; t < NT; t++) begin
            int maxp, p;
            maxp = 0;
            nid[t] = 0;
            for (int s = 1; s < NS; s++) begin
                p = int'(prio[s*PW +: PW]);
                if (m_pend[s] && ie[t*NS+s] && p > maxp) maxp = p;
            end
            for (int s = 1; s < NS; s++) begin
                p = int'(prio[s*PW +: PW]);
                if (maxp > 0 && nid[t] == 0 && m_pend[s] && ie[t*NS+s] && p == maxp) nid[t] = s;
            end
            nirq[t] = maxp > int'(thr[t*PW +: PW]);
        end
        for (int s = 0; s < NS; s++) begin
            got[s] = 0; done[s] = 0;
        end
        for (int t = 0; t < NT; t++) begin
            int c;
            c = int'(cid[t*SW +: SW]);
            if (m_grant[t]) got[m_id[t]] = 1;
            if (complete[t] && c != 0 && c < NS) done[c] = 1;
        end
        for (int s = 1; s < NS; s++) begin
            bit edg, trg;
            edg = le[s] && src[s] && !m_prev[s];
            trg = le[s] ? edg : src[s];
            if (got[s]) begin m_pend[s] = 0; m_clm[s] = 1; end
            if (m_clm[s]) begin
                if (done[s]) begin
                    m_clm[s] = 0;
                    if (m_cnt[s] > 0) begin
                        m_pend[s] = 1;
                        m_cnt[s]  = m_cnt[s] - 1 + (edg ? 1 : 0);
                    end else begin
                        m_pend[s] = trg;
                    end
                end else if (edg && m_cnt[s] < CMAX) begin
                    m_cnt[s]++;
                end
            end else if (m_pend[s]) begin
                if (edg && m_cnt[s] < CMAX) m_cnt[s]++;
            end else if (trg) begin
                m_pend[s] = 1;
            end
        end
        for (int s = 0; s < NS; s++) m_prev[s] = src[s];
        for (int t = 0; t < NT; t++) begin
            m_irq[t] = nirq[t];
            m_id[t]  = nirq[t] ? nid[t] : 0;
        end
    endtask

    logic [NS-1:0]    e_ip;
    logic [NT-1:0]    e_irq;
    logic [NT*SW-1:0] e_id, e_cl;

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        model_claims();
        for (int s = 0; s < NS; s++) e_ip[s] = m_pend[s];
        for (int t = 0; t < NT; t++) begin
            e_irq[t]          = m_irq[t];
            e_id[t*SW +: SW]  = SW'(m_id[t]);
            e_cl[t*SW +: SW]  = SW'(m_cl[t]);
        end
        chk("ip_o", 64'(ip), 64'(e_ip));
        chk("irq_o", 64'(irq), 64'(e_irq));
        chk("irq_id_o", 64'(irq_id), 64'(e_id));
        chk("claim_id_o", 64'(claim_id), 64'(e_cl));
        if (rst_n) model_step();
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_prio(input int s, input int p);
        prio[s*PW +: PW] = PW'(p);
    endtask

    task automatic do_claim(input int t, output int got);
        claim[t] = 1'b1;
        #1;
        got = int'(claim_id[t*SW +: SW]);
        @(posedge clk);
        #1;
        claim[t] = 1'b0;
    endtask

    task automatic do_complete(input int t, input int id);
        complete[t]      = 1'b1;
        cid[t*SW +: SW]  = SW'(id);
        tick(1);
        complete[t]      = 1'b0;
        cid              = '0;
    endtask

    int got;

    initial begin
        rst_n = 1'b0; src = '0; le = '0; prio = '0; ie = '0; thr = '0;
        claim = '0; complete = '0; cid = '0;
        tick(2);
        chk("reset_ip", 64'(ip), 64'd0);
        chk("reset_irq_id", 64'(irq_id), 64'd0);
        rst_n = 1'b1;
        tick(1);

        // Level source 5
        set_prio(5, 3); ie[5] = 1'b1; thr[2:0] = 3'd1; src[5] = 1'b1;
        tick(1);
        chk("lvl_ip5", 64'(ip[5]), 64'd1);
        chk("lvl_irq_early", 64'(irq[0]), 64'd0);
        tick(1);
        chk("lvl_irq", 64'(irq[0]), 64'd1);
        chk("lvl_irq_id", 64'(irq_id[5:0]), 64'd5);
        do_claim(0, got);
        chk("lvl_claim", 64'(got), 64'd5);
        chk("lvl_ip5_claimed", 64'(ip[5]), 64'd0);
        tick(1);
        do_complete(0, 5);
        chk("lvl_repend", 64'(ip[5]), 64'd1);
        src[5] = 1'b0;
        tick(1);
        do_claim(0, got);
        do_complete(0, 5);
        chk("lvl_idle", 64'(ip[5]), 64'd0);
        ie[5] = 1'b0;

        // Priority ordering and threshold
        set_prio(3, 4); set_prio(9, 4); set_prio(12, 2);
        ie[3] = 1'b1; ie[9] = 1'b1; ie[12] = 1'b1;
        src[3] = 1'b1; src[9] = 1'b1; src[12] = 1'b1;
        tick(2);
        chk("arb_first", 64'(irq_id[5:0]), 64'd3);
        do_claim(0, got);
        chk("arb_claim3", 64'(got), 64'd3);
        tick(1);
        chk("arb_second", 64'(irq_id[5:0]), 64'd9);
        do_claim(0, got);
        tick(1);
        chk("arb_third", 64'(irq_id[5:0]), 64'd12);
        complete = 2'b11; cid = {6'd9, 6'd3};
        tick(1);
        complete = '0; cid = '0;
        tick(1);
        chk("arb_back3", 64'(irq_id[5:0]), 64'd3);
        thr[2:0] = 3'd4;
        tick(1);
        chk("thr_irq", 64'(irq[0]), 64'd0);
        chk("thr_id", 64'(irq_id[5:0]), 64'd0);
        src[3] = 1'b0; src[9] = 1'b0; src[12] = 1'b0;
        ie[3] = 1'b0; ie[9] = 1'b0; ie[12] = 1'b0; thr = '0;

        // Edge source 7 with queued edges
        le[7] = 1'b1; set_prio(7, 5); ie[7] = 1'b1; src[7] = 1'b1;
        tick(1);
        chk("edge_ip7", 64'(ip[7]), 64'd1);
        src[7] = 1'b0;
        tick(1);
        do_claim(0, got);
        chk("edge_claim", 64'(got), 64'd7);
        repeat (5) begin
            src[7] = 1'b1; tick(1);
            src[7] = 1'b0; tick(1);
        end
        chk("edge_claimed_ip", 64'(ip[7]), 64'd0);
        for (int k = 0; k < 3; k++) begin
            do_complete(0, 7);
            chk("edge_requeue", 64'(ip[7]), 64'd1);
            tick(1);
            do_claim(0, got);
            chk("edge_reclaim", 64'(got), 64'd7);
        end
        do_complete(0, 7);
        chk("edge_drained", 64'(ip[7]), 64'd0);
        tick(2);
        chk("edge_stays_idle", 64'(ip[7]), 64'd0);

        // Claim race between targets
        set_prio(4, 6); ie[4] = 1'b1; ie[NS+4] = 1'b1; src[4] = 1'b1;
        tick(2);
        chk("race_id1", 64'(irq_id[11:6]), 64'd4);
        claim = 2'b11;
        #1;
        chk("race_t0", 64'(claim_id[5:0]), 64'd4);
        chk("race_t1", 64'(claim_id[11:6]), 64'd0);
        tick(1);
        claim = '0;
        chk("race_ip4", 64'(ip[4]), 64'd0);
        src[4] = 1'b0;
        do_complete(1, 4);
        chk("race_done", 64'(ip[4]), 64'd0);

        // Ignored completes: IDLE source, ID 0, PENDING source
        complete = 2'b11; cid = {6'd0, 6'd4};
        tick(1);
        complete = '0; cid = '0;
        do_complete(0, 12);
        chk("ign_ip4", 64'(ip[4]), 64'd0);
        chk("ign_ip12", 64'(ip[12]), 64'd1);
        chk("ign_ip3", 64'(ip[3]), 64'd1);

        // Reset while source 7 is CLAIMED with two queued edges
        src[7] = 1'b1; tick(1); src[7] = 1'b0; tick(1);
        do_claim(0, got);
        repeat (2) begin
            src[7] = 1'b1; tick(1);
            src[7] = 1'b0; tick(1);
        end
        rst_n = 1'b0;
        #1;
        chk("arst_ip", 64'(ip), 64'd0);
        chk("arst_irq", 64'(irq), 64'd0);
        chk("arst_id", 64'(irq_id), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_ip", 64'(ip), 64'd0);
        src[7] = 1'b1;
        tick(1);
        chk("post_rst_pend", 64'(ip[7]), 64'd1);
        src[7] = 1'b0;
        tick(1);
        chk("post_rst_id", 64'(irq_id[5:0]), 64'd7);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv_plic_core.md
Name: rv_plic_core

Overview:
Parametrised interrupt-controller core: per-source gateways, per-target priority arbitration and claim/complete handling, with no register file. It extends the fixed-size PLIC in three ways: source count, target count and priority depth are parameters; edge sources count queued edges; and a single block resolves same-cycle claim races between targets. A register-file wrapper drives its configuration ports and maps the CC register accesses onto the claim/complete ports.

Parameters:
NumSrc, 64, number of interrupt sources including reserved source 0 (>=2)
NumTarget, 2, number of interrupt targets (>=1)
MaxPrio, 7, highest priority value; PrioW = $clog2(MaxPrio+1)
EdgeCntW, 2, width of the per-source saturating queued-edge counter (>=1)
SrcW, $clog2(NumSrc), derived ID width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
intr_src_i  in  NumSrc  raw interrupt lines; bit 0 ignored
le_i  in  NumSrc  trigger mode per source: 0 level, 1 rising edge
prio_i  in  NumSrc*PrioW  priority per source, packed by source index
ie_i  in  NumTarget*NumSrc  enable per target, packed with target-major ordering
threshold_i  in  NumTarget*PrioW  threshold per target
claim_i  in  NumTarget  claim strobe per target (CC read)
claim_id_o  out  NumTarget*SrcW  ID returned for the claim, valid in the same cycle as claim_i
complete_i  in  NumTarget  complete strobe per target (CC write)
complete_id_i  in  NumTarget*SrcW  ID being completed
ip_o  out  NumSrc  pending bits
irq_o  out  NumTarget  interrupt request per target
irq_id_o  out  NumTarget*SrcW  highest-priority pending ID per target

Behaviour:
- Reset (asynchronous, active-low):
  - All gateways go to IDLE.
  - Edge counters and the previous-source register clear to 0.
  - ip_o, irq_o and irq_id_o are 0.
- Source 0 is reserved: it never pends, its ip_o bit is 0, and claims or completes naming ID 0 are ignored.
- Gateway per source s >= 1 has three states: IDLE, PENDING, CLAIMED. ip_o[s] = (state == PENDING), taken from the register.
- Trigger detection:
  - Level mode: trig = intr_src_i[s].
  - Edge mode: trig = intr_src_i[s] & ~src_q[s], where src_q is a 1-cycle register of intr_src_i.
- Gateway transitions:
  - IDLE -> PENDING on trig; ip is visible one cycle after the sampled edge or level.
  - PENDING -> CLAIMED on a granted claim of s.
  - PENDING with an edge trig: cnt increments, saturating at 2^EdgeCntW-1.
  - CLAIMED with an edge trig: cnt increments, saturating.
  - CLAIMED with a level trig: no effect; the line is re-sampled after complete.
  - CLAIMED -> on complete of s:
    - If cnt > 0: go to PENDING and decrement cnt.
    - Else if trig is active in that cycle: go to PENDING.
    - Else: go to IDLE.
  - Complete of an ID that is not CLAIMED is ignored, with no state change.
- A change of le_i while a source is non-IDLE takes effect only on the next trigger evaluation. The counter is not cleared.
- Arbitration per target t:
  - Candidates: sources with ip[s] & ie[t][s] & (prio[s] > 0).
  - Winner: highest prio; on equal prio the lower ID wins.
  - irq_o[t] = winner exists & (prio[winner] > threshold[t]).
  - irq_id_o[t] = winner ID when irq_o[t] is 1, else 0.
  - Both are registered: a one-cycle latency from an ip_o or configuration change to irq_o/irq_id_o.
- Claim handling, combinational in the claim cycle:
  - The candidate ID is irq_id_o[t].
  - The claim is granted iff the ID != 0, the source is PENDING in that cycle, and no lower-index target claims the same ID in the same cycle.
  - Granted: claim_id_o[t] = ID, and the gateway moves to CLAIMED on the next clock edge.
  - Not granted (lost race, stale ID, or irq low): claim_id_o[t] = 0, with no state change.
  - claim_id_o[t] is 0 whenever claim_i[t] is low.
- Complete handling:
  - Multiple targets may complete in the same cycle.
  - Duplicate IDs act once.
  - A complete and a claim of the same source in the same cycle are resolved as: the claim sees the pre-edge state, and the complete sees CLAIMED.
- Every packed input is treated as a plain vector. Out-of-range IDs (>= NumSrc) on complete_id_i are ignored.

Test Plan:
- Level source 5, prio 3, ie[0][5]=1, threshold0=1 -> ip_o[5] high 1 cycle after the input; irq_o[0]=1 and irq_id_o[0]=5 one cycle later. Claim -> claim_id_o[0]=5, ip_o[5]=0. Complete 5 with the line still high -> re-pends.
- Sources 3 and 9 both prio 4, source 12 prio 2, all enabled -> irq_id_o=3. Claim 3 -> next winner is 9, then 12. threshold0=4 -> irq_o[0]=0.
- Edge source 7, EdgeCntW=2: five rising edges while CLAIMED -> cnt saturates at 3. Each complete re-pends: the source pends 3 more times, then returns to IDLE.
- Both targets enabled for source 4, claims in the same cycle -> claim_id_o[0]=4, claim_id_o[1]=0. Source 4 is CLAIMED once.
- Complete of ID 4 while IDLE, and complete of ID 0 -> no state change, ip_o unchanged.
- Reset asserted mid-CLAIMED with cnt=2 -> immediately irq_o=0, ip_o=0, all IDs 0. After release, a source pends only on a new trigger.
